// File: rtl/id_squash_ctrl.sv
// id_squash_ctrl: ID-stage squash controller. After a control-flow redirect it
// replaces the fetched instruction with a NOP for a configurable window. Stalls
// freeze the window and the held instruction. It also reports the last redirect
// cause and keeps a saturating count of the bubbles it has issued.
module id_squash_ctrl #(
    parameter int unsigned              INST_W        = 32,
    parameter logic [INST_W-1:0]        NOP_INST      = 32'h00000013,
    parameter int unsigned              SQUASH_CYCLES = 2,
    parameter int unsigned              CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_in,
    input  logic              inst_valid_in,
    input  logic              stall,
    input  logic              ev_branch,
    input  logic              ev_mret,
    input  logic              ev_trap,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid_out,
    output logic              squash_active,
    output logic [1:0]        squash_cause,
    output logic [CNT_W-1:0]  squash_cnt,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_BRANCH = 2'b01,
        CAUSE_MRET   = 2'b10,
        CAUSE_TRAP   = 2'b11
    } cause_e;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SQUASH_CYCLES - 1);

    logic              redirect;
    cause_e            cause_sel;

    logic [CNT_W-1:0]  squash_cnt_d,   squash_cnt_q;
    cause_e            squash_cause_d, squash_cause_q;
    logic [15:0]       bubble_cnt_d,   bubble_cnt_q;
    logic [INST_W-1:0] hold_inst_d,    hold_inst_q;
    logic              hold_valid_d,   hold_valid_q;

    // Redirect detection and cause priority (trap > mret > branch).
    always_comb begin
        redirect  = ev_branch | ev_mret | ev_trap;
        cause_sel = CAUSE_NONE;
        if (ev_trap) begin
            cause_sel = CAUSE_TRAP;
        end else if (ev_mret) begin
            cause_sel = CAUSE_MRET;
        end else if (ev_branch) begin
            cause_sel = CAUSE_BRANCH;
        end
    end

    // Output select: a bubble wins, then the held instruction, then pass-through.
    always_comb begin
        squash_active  = redirect | (squash_cnt_q != '0);
        inst_out       = inst_in;
        inst_valid_out = inst_valid_in;
        if (squash_active) begin
            inst_out       = NOP_INST;
            inst_valid_out = 1'b0;
        end else if (stall) begin
            inst_out       = hold_inst_q;
            inst_valid_out = hold_valid_q;
        end
    end

    // Next-state for window counter, cause, bubble counter and hold register.
    always_comb begin
        squash_cnt_d   = squash_cnt_q;
        squash_cause_d = squash_cause_q;
        bubble_cnt_d   = bubble_cnt_q;
        hold_inst_d    = hold_inst_q;
        hold_valid_d   = hold_valid_q;

        // A redirect restarts the window even while stalled; stall only freezes.
        if (redirect) begin
            squash_cnt_d   = CNT_RELOAD;
            squash_cause_d = cause_sel;
        end else if (!stall && (squash_cnt_q != '0)) begin
            squash_cnt_d = squash_cnt_q - 1'b1;
        end

        if (squash_active && !stall && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end

        // A redirect arriving during a stall poisons the hold register so the
        // release after the window cannot replay the stale instruction.
        if (!stall) begin
            hold_inst_d  = inst_out;
            hold_valid_d = inst_valid_out;
        end else if (redirect) begin
            hold_inst_d  = NOP_INST;
            hold_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_cnt_q   <= '0;
            squash_cause_q <= CAUSE_NONE;
            bubble_cnt_q   <= '0;
            hold_inst_q    <= NOP_INST;
            hold_valid_q   <= 1'b0;
        end else begin
            squash_cnt_q   <= squash_cnt_d;
            squash_cause_q <= squash_cause_d;
            bubble_cnt_q   <= bubble_cnt_d;
            hold_inst_q    <= hold_inst_d;
            hold_valid_q   <= hold_valid_d;
        end
    end

    assign squash_cnt   = squash_cnt_q;
    assign squash_cause = squash_cause_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_squash_ctrl.sv
// tb_id_squash_ctrl: drives two instances (window 2 and window 3) with the same
// stimulus and compares both against a cycle-level reference model, plus a
// table of hand-derived expectations and a few multi-cycle corner sequences.
module tb_id_squash_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b1;
    logic        rst;
    logic [31:0] inst_in;
    logic        inst_valid_in;
    logic        stall;
    logic        ev_branch;
    logic        ev_mret;
    logic        ev_trap;

    logic [31:0] o_inst   [2];
    logic        o_valid  [2];
    logic        o_active [2];
    logic [1:0]  o_cause  [2];
    logic [2:0]  o_cnt    [2];
    logic [15:0] o_bub    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_squash_ctrl #(.INST_W(32), .NOP_INST(NOP), .SQUASH_CYCLES(2), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid_in(inst_valid_in),
        .stall(stall), .ev_branch(ev_branch), .ev_mret(ev_mret), .ev_trap(ev_trap),
        .inst_out(o_inst[0]), .inst_valid_out(o_valid[0]), .squash_active(o_active[0]),
        .squash_cause(o_cause[0]), .squash_cnt(o_cnt[0]), .bubble_cnt(o_bub[0])
    );

    id_squash_ctrl #(.INST_W(32), .NOP_INST(NOP), .SQUASH_CYCLES(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid_in(inst_valid_in),
        .stall(stall), .ev_branch(ev_branch), .ev_mret(ev_mret), .ev_trap(ev_trap),
        .inst_out(o_inst[1]), .inst_valid_out(o_valid[1]), .squash_active(o_active[1]),
        .squash_cause(o_cause[1]), .squash_cnt(o_cnt[1]), .bubble_cnt(o_bub[1])
    );

    // Reference model: remaining NOP cycles after the current one, last cause,
    // bubbles issued, and the instruction/valid seen in the last unstalled cycle.
    int          win   [2] = '{2, 3};
    int          m_rem [2];
    int          m_cause [2];
    int          m_bub [2];
    logic [31:0] m_hi  [2];
    logic        m_hv  [2];
    bit          m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit any_ev();
        return ev_branch | ev_mret | ev_trap;
    endfunction

    task automatic drive(input logic r, input logic [31:0] i, input logic v,
                         input logic s, input logic b, input logic m, input logic t);
        rst = r; inst_in = i; inst_valid_in = v; stall = s;
        ev_branch = b; ev_mret = m; ev_trap = t;
    endtask

    task automatic check_model();
        if (m_known) begin
            for (int k = 0; k < 2; k++) begin
                bit          act;
                logic [31:0] ei;
                logic        ev;
                act = any_ev() || (m_rem[k] > 0);
                if (act)        begin ei = NOP;      ev = 1'b0;     end
                else if (stall) begin ei = m_hi[k];  ev = m_hv[k];  end
                else            begin ei = inst_in;  ev = inst_valid_in; end
                chk($sformatf("model%0d.inst", win[k]),   o_inst[k],   ei);
                chk($sformatf("model%0d.valid", win[k]),  32'(o_valid[k]),  32'(ev));
                chk($sformatf("model%0d.active", win[k]), 32'(o_active[k]), 32'(act));
                chk($sformatf("model%0d.cause", win[k]),  32'(o_cause[k]),  32'(m_cause[k]));
                chk($sformatf("model%0d.cnt", win[k]),    32'(o_cnt[k]),    32'(m_rem[k]));
                chk($sformatf("model%0d.bub", win[k]),    32'(o_bub[k]),    32'(m_bub[k]));
            end
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            bit          act;
            logic [31:0] oi;
            logic        ov;
            act = any_ev() || (m_rem[k] > 0);
            oi  = act ? NOP  : (stall ? m_hi[k] : inst_in);
            ov  = act ? 1'b0 : (stall ? m_hv[k] : inst_valid_in);
            if (rst) begin
                m_rem[k] = 0; m_cause[k] = 0; m_bub[k] = 0; m_hi[k] = NOP; m_hv[k] = 1'b0;
            end else begin
                if (act && !stall && m_bub[k] < 65535) m_bub[k]++;
                if (any_ev()) begin
                    m_rem[k]   = win[k] - 1;
                    m_cause[k] = ev_trap ? 3 : (ev_mret ? 2 : 1);
                end else if (!stall && m_rem[k] > 0) begin
                    m_rem[k]--;
                end
                if (!stall) begin
                    m_hi[k] = oi; m_hv[k] = ov;
                end else if (any_ev()) begin
                    m_hi[k] = NOP; m_hv[k] = 1'b0;
                end
            end
        end
        if (rst) m_known = 1'b1;
    endtask

    task automatic cycle(input logic r, input logic [31:0] i, input logic v,
                         input logic s, input logic b, input logic m, input logic t);
        drive(r, i, v, s, b, m, t);
        @(negedge clk);
        check_model();
        @(posedge clk);
        advance();
        #1;
    endtask

    typedef struct {
        logic        rst, v, s, b, m, t, chk_en;
        logic [31:0] inst;
        logic [31:0] e_inst;
        logic        e_valid, e_act;
        logic [1:0]  e_cause;
        logic [2:0]  e_cnt;
        logic [15:0] e_bub;
    } vec_t;

    vec_t tab [21];

    function automatic vec_t mk(input logic r, input logic [31:0] i, input logic v, input logic s,
                                input logic b, input logic m, input logic t, input logic ce,
                                input logic [31:0] ei, input logic ev, input logic ea,
                                input logic [1:0] ec, input logic [2:0] en, input logic [15:0] eb);
        vec_t x;
        x.rst = r; x.inst = i; x.v = v; x.s = s; x.b = b; x.m = m; x.t = t; x.chk_en = ce;
        x.e_inst = ei; x.e_valid = ev; x.e_act = ea; x.e_cause = ec; x.e_cnt = en; x.e_bub = eb;
        return x;
    endfunction

    initial begin
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expectations for the window-2 instance; outputs before the clock edge.
        //           rst inst          v  s  b  m  t  chk  exp_inst      v  act cause cnt bub
        tab[0]  = mk(1, 32'h00000000, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0);
        tab[1]  = mk(0, 32'h00500093, 1, 0, 0, 0, 0, 1, 32'h00500093, 1, 0, 0, 0, 0);
        tab[2]  = mk(0, 32'h00A00113, 1, 0, 1, 0, 0, 1, NOP,          0, 1, 0, 0, 0);
        tab[3]  = mk(0, 32'h00A00113, 1, 0, 0, 0, 0, 1, NOP,          0, 1, 1, 1, 1);
        tab[4]  = mk(0, 32'h00A00113, 1, 0, 0, 0, 0, 1, 32'h00A00113, 1, 0, 1, 0, 2);
        tab[5]  = mk(0, 32'h00B00193, 1, 0, 1, 0, 1, 1, NOP,          0, 1, 1, 0, 2);
        tab[6]  = mk(0, 32'h00B00193, 1, 0, 0, 1, 0, 1, NOP,          0, 1, 3, 1, 3);
        tab[7]  = mk(0, 32'h00B00193, 1, 0, 0, 0, 0, 1, NOP,          0, 1, 2, 1, 4);
        tab[8]  = mk(0, 32'h00B00193, 1, 0, 0, 0, 0, 1, 32'h00B00193, 1, 0, 2, 0, 5);
        tab[9]  = mk(0, 32'h00C00213, 1, 0, 0, 0, 0, 1, 32'h00C00213, 1, 0, 2, 0, 5);
        tab[10] = mk(0, 32'h00D00293, 1, 1, 0, 0, 0, 1, 32'h00C00213, 1, 0, 2, 0, 5);
        tab[11] = mk(0, 32'h00D00293, 1, 1, 1, 0, 0, 1, NOP,          0, 1, 2, 0, 5);
        tab[12] = mk(0, 32'h00D00293, 1, 1, 0, 0, 0, 1, NOP,          0, 1, 1, 1, 5);
        tab[13] = mk(0, 32'h00D00293, 0, 0, 0, 0, 0, 1, NOP,          0, 1, 1, 1, 5);
        tab[14] = mk(0, 32'h00D00293, 0, 1, 0, 0, 0, 1, NOP,          0, 0, 1, 0, 6);
        tab[15] = mk(0, 32'h00E00313, 1, 0, 0, 0, 0, 1, 32'h00E00313, 1, 0, 1, 0, 6);
        tab[16] = mk(0, 32'h00E00313, 1, 0, 1, 0, 0, 1, NOP,          0, 1, 1, 0, 6);
        tab[17] = mk(1, 32'h00E00313, 1, 0, 0, 0, 0, 1, NOP,          0, 1, 1, 1, 7);
        tab[18] = mk(0, 32'h00F00393, 1, 0, 0, 0, 0, 1, 32'h00F00393, 1, 0, 0, 0, 0);
        tab[19] = mk(1, 32'h00F00393, 1, 0, 1, 0, 0, 1, NOP,          0, 1, 0, 0, 0);
        tab[20] = mk(0, 32'h01000413, 1, 0, 0, 0, 0, 1, 32'h01000413, 1, 0, 0, 0, 0);

        #1;
        for (int r = 0; r < 21; r++) begin
            drive(tab[r].rst, tab[r].inst, tab[r].v, tab[r].s, tab[r].b, tab[r].m, tab[r].t);
            @(negedge clk);
            check_model();
            if (tab[r].chk_en) begin
                chk($sformatf("tab%0d.inst", r),   o_inst[0],         tab[r].e_inst);
                chk($sformatf("tab%0d.valid", r),  32'(o_valid[0]),   32'(tab[r].e_valid));
                chk($sformatf("tab%0d.active", r), 32'(o_active[0]),  32'(tab[r].e_act));
                chk($sformatf("tab%0d.cause", r),  32'(o_cause[0]),   32'(tab[r].e_cause));
                chk($sformatf("tab%0d.cnt", r),    32'(o_cnt[0]),     32'(tab[r].e_cnt));
                chk($sformatf("tab%0d.bub", r),    32'(o_bub[0]),     32'(tab[r].e_bub));
            end
            @(posedge clk);
            advance();
            #1;
        end

        // Window 3 with a two-cycle stall inside: NOP T..T+4, counter frozen at 2.
        cycle(1, 32'h0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            logic [2:0] e_cnt [6] = '{0, 2, 2, 2, 1, 0};
            drive(0, 32'h02000513 + 32'(c), 1, (c == 1 || c == 2), (c == 0), 0, 0);
            @(negedge clk);
            check_model();
            chk($sformatf("stall3.cnt%0d", c),    32'(o_cnt[1]),    32'(e_cnt[c]));
            chk($sformatf("stall3.active%0d", c), 32'(o_active[1]), 32'(c < 5));
            if (c == 5) chk("stall3.bub", 32'(o_bub[1]), 32'd3);
            @(posedge clk);
            advance();
            #1;
        end

        // Reset at T+1 of a window-3 window: T+2 passes through with reset outputs.
        cycle(0, 32'h03000613, 1, 0, 1, 0, 0);
        cycle(1, 32'h03000613, 1, 0, 0, 0, 0);
        drive(0, 32'h03100693, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_model();
        chk("rstmid.inst",   o_inst[1],        32'h03100693);
        chk("rstmid.active", 32'(o_active[1]), 32'd0);
        chk("rstmid.cause",  32'(o_cause[1]),  32'd0);
        chk("rstmid.cnt",    32'(o_cnt[1]),    32'd0);
        chk("rstmid.bub",    32'(o_bub[1]),    32'd0);
        @(posedge clk);
        advance();
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(63) == 0), $urandom, 1'($urandom), ($urandom_range(3) == 0),
                  ($urandom_range(9) == 0), ($urandom_range(19) == 0), ($urandom_range(29) == 0));
        end

        // Saturation: continuous redirects issue one bubble per cycle.
        cycle(1, 32'h0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65534; n++) begin
            drive(0, 32'h0, 0, 0, 1, 0, 0);
            @(posedge clk);
            advance();
            #1;
        end
        @(negedge clk);
        chk("sat.fffe2", 32'(o_bub[0]), 32'h0000FFFE);
        chk("sat.fffe3", 32'(o_bub[1]), 32'h0000FFFE);
        @(posedge clk); advance(); #1;
        cycle(0, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat.ffff2", 32'(o_bub[0]), 32'h0000FFFF);
        chk("sat.ffff3", 32'(o_bub[1]), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
